cordic_gain_comp: RTL and testbench

Pipelined, parametrised CORDIC gain-compensation stage that multiplies each of `LANES` signed fixed-point samples by either the CORDIC gain K (≈1.6467597) or its inverse 1/K (≈0.6072529), selectable per sample. It sits between the CORDIC rotation core and downstream consumers and carries an ID tag alongside each sample. It adds valid/ready backpressure, rounding, and optional saturation. It is the successor to the fixed Q4.8, single-value scaler.

---
 rtl/cordic_pkg.sv | 15 +
 rtl/gain_mul_lane.sv | 72 +++++++
 rtl/cordic_gain_comp.sv | 97 +++++++++
 tb/tb_cordic_gain_comp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and mode encoding for the CORDIC gain-compensation stage.
// Gains are unsigned Q2.14; GAIN_FRAC_W gives the shift that returns to sample format.
// No ports. Optional feature macro used by the stage: CORDIC_GAIN_SAT_EN.
package cordic_pkg;

  localparam int          GAIN_FRAC_W = 14;
  localparam logic [15:0] GAIN_K      = 16'd26981;  // ~1.6467597
  localparam logic [15:0] GAIN_INV_K  = 16'd9949;   // ~0.6072529

  typedef enum logic {
    MODE_K     = 1'b0,
    MODE_INV_K = 1'b1
  } gain_mode_e;

endpackage

// File: rtl/gain_mul_lane.sv
// One lane of the gain stage: S2 product register, S3 round/reduce/result register.
// Ports: clock/reset_n, load_s2/load_s3 stage enables, sample+mode from S1, result (+sat).
// CORDIC_GAIN_SAT_EN selects clamping with a sat flag; otherwise the result wraps.
module gain_mul_lane
  import cordic_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     load_s2,
  input  logic                     load_s3,
  input  logic signed [DATA_W-1:0] sample,
  input  gain_mode_e               mode,
  output logic signed [DATA_W-1:0] result
`ifdef CORDIC_GAIN_SAT_EN
  ,
  output logic                     sat
`endif
);

  localparam int PW = DATA_W + 16;
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(2 ** (GAIN_FRAC_W - 1));

  logic signed [16:0]       coef;
  logic signed [PW-1:0]     prod_d;
  logic signed [PW-1:0]     prod_q;
  logic signed [PW-1:0]     shifted;
  logic signed [DATA_W-1:0] reduced;

  // Constants are positive and below 2^15, so a zero-extended 17-bit signed form is exact.
  assign coef    = (mode == MODE_INV_K) ? $signed({1'b0, GAIN_INV_K}) : $signed({1'b0, GAIN_K});
  assign prod_d  = PW'(sample) * PW'(coef);
  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  assign shifted = (prod_q + ROUND_HALF) >>> GAIN_FRAC_W;

`ifdef CORDIC_GAIN_SAT_EN
  logic [PW-DATA_W:0] hi;
  logic               ovf;

  // The value fits in DATA_W bits only if every bit from the kept sign bit upward agrees.
  always_comb begin
    hi      = shifted[PW-1:DATA_W-1];
    ovf     = !((&hi) || !(|hi));
    reduced = DATA_W'(shifted);
    if (ovf) begin
      reduced = shifted[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign reduced = DATA_W'(shifted);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      result <= '0;
`ifdef CORDIC_GAIN_SAT_EN
      sat    <= 1'b0;
`endif
    end else begin
      if (load_s2) prod_q <= prod_d;
      if (load_s3) begin
        result <= reduced;
`ifdef CORDIC_GAIN_SAT_EN
        sat    <= ovf;
`endif
      end
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: scales LANES samples by K or 1/K, 3-stage valid/ready pipeline.
// Ports: clock/reset_n; in_valid/in_ready/in_data/in_mode/in_id; out_valid/out_ready/out_data/out_id.
// CORDIC_GAIN_SAT_EN adds per-lane out_sat and clamping; without it results wrap.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int FRAC_W   = 8,
  parameter int LANES    = 2,
  parameter int ID_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_mode,
  input  logic [ID_WIDTH-1:0]       in_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [ID_WIDTH-1:0]       out_id
`ifdef CORDIC_GAIN_SAT_EN
  ,
  output logic [LANES-1:0]          out_sat
`endif
);

  // Input and output share one Q format, so FRAC_W never enters the arithmetic;
  // it only has to describe a legal format.
  if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_frac_check
    $error("FRAC_W must lie in [0, DATA_W)");
  end

  logic v1, v2, v3;
  logic ready_1, ready_2, ready_3;
  logic load_1, load_2, load_3;

  logic [LANES*DATA_W-1:0] s1_data;
  gain_mode_e              s1_mode;
  logic [ID_WIDTH-1:0]     s1_id;
  logic [ID_WIDTH-1:0]     s2_id;

  // Each stage may load when it is empty or its successor is moving, so bubbles collapse.
  assign ready_3   = !v3 || out_ready;
  assign ready_2   = !v2 || ready_3;
  assign ready_1   = !v1 || ready_2;
  assign in_ready  = ready_1;
  assign out_valid = v3;

  assign load_1 = in_valid && ready_1;
  assign load_2 = v1 && ready_2;
  assign load_3 = v2 && ready_3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_data <= '0;
      s1_mode <= MODE_K;
      s1_id   <= '0;
      s2_id   <= '0;
      out_id  <= '0;
    end else begin
      if (ready_1) v1 <= in_valid;
      if (ready_2) v2 <= v1;
      if (ready_3) v3 <= v2;
      if (load_1) begin
        s1_data <= in_data;
        s1_mode <= gain_mode_e'(in_mode);
        s1_id   <= in_id;
      end
      if (load_2) s2_id  <= s1_id;
      if (load_3) out_id <= s2_id;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gain_mul_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .load_s2 (load_2),
      .load_s3 (load_3),
      .sample  (s1_data[l*DATA_W +: DATA_W]),
      .mode    (s1_mode),
      .result  (out_data[l*DATA_W +: DATA_W])
`ifdef CORDIC_GAIN_SAT_EN
      ,
      .sat     (out_sat[l])
`endif
    );
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Scoreboard bench for cordic_gain_comp at default parameters.
module tb_cordic_gain_comp;

  localparam int DATA_W   = 12;
  localparam int LANES    = 2;
  localparam int ID_WIDTH = 8;
  localparam int DW       = LANES * DATA_W;

  typedef struct packed {
    logic [DW-1:0]       data;
    logic [ID_WIDTH-1:0] id;
    logic [LANES-1:0]    sat;
  } tok_t;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DW-1:0]       in_data = '0;
  logic                in_mode = 1'b0;
  logic [ID_WIDTH-1:0] in_id = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       out_data;
  logic [ID_WIDTH-1:0] out_id;
`ifdef CORDIC_GAIN_SAT_EN
  logic [LANES-1:0]    out_sat;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  tok_t sb[$];
  int   pop_cyc[$];
  tok_t exp_t;

  cordic_gain_comp dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef CORDIC_GAIN_SAT_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack2(input int a, input int b);
    logic [DATA_W-1:0] la, lb;
    la = DATA_W'(a);
    lb = DATA_W'(b);
    return {lb, la};
  endfunction

  // Reference arithmetic: exact integer product, +2^13, floor-shift by 14, then reduce.
  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] s, input logic m,
                                              output logic sat);
    longint p, r;
    p   = longint'($signed(s)) * (m ? 64'sd9949 : 64'sd26981);
    r   = (p + 64'sd8192) >>> 14;
    sat = 1'b0;
`ifdef CORDIC_GAIN_SAT_EN
    if (r > 2047) begin
      r = 2047; sat = 1'b1;
    end else if (r < -2048) begin
      r = -2048; sat = 1'b1;
    end
`endif
    return DATA_W'(r);
  endfunction

  function automatic tok_t mk(input logic [DW-1:0] d, input logic m, input logic [ID_WIDTH-1:0] id);
    tok_t t;
    logic s;
    t.id  = id;
    t.sat = '0;
    for (int l = 0; l < LANES; l++) begin
      t.data[l*DATA_W +: DATA_W] = model(d[l*DATA_W +: DATA_W], m, s);
      t.sat[l] = s;
    end
    return t;
  endfunction

  // Called just after a rising edge; returns just after the edge that captured the token.
  task automatic send(input logic [DW-1:0] d, input logic m, input logic [ID_WIDTH-1:0] id,
                      input tok_t exp);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_id = id;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("send_timeout", 1'b0, 1'b1);
    else sb.push_back(exp);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out", 1'b1, 1'b0);
      end else if (out_ready) begin
        exp_t = sb.pop_front();
        check("out_data", out_data, exp_t.data);
        check("out_id", out_id, exp_t.id);
`ifdef CORDIC_GAIN_SAT_EN
        check("out_sat", out_sat, exp_t.sat);
`endif
        pop_cyc.push_back(cyc);
      end else begin
        check("stall_data", out_data, sb[0].data);
        check("stall_id", out_id, sb[0].id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tok_t t;
    int   nacc, acc_cyc, sid;
    logic rnd_done;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_id", out_id, '0);
`ifdef CORDIC_GAIN_SAT_EN
    check("rst_out_sat", out_sat, '0);
`endif
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid_rel", out_valid, 1'b0);
    @(posedge clock); #1;

    // Single token, latency 3
    out_ready = 1'b1;
    t.data = pack2(422, -422); t.id = 8'd1; t.sat = '0;
    send(pack2(256, -256), 1'b0, 8'd1, t);
    @(negedge clock); check("lat_c1", out_valid, 1'b0);
    @(negedge clock); check("lat_c2", out_valid, 1'b0);
    @(negedge clock); check("lat_c3", out_valid, 1'b1);
    wait_drain("drain_k");

    // Directed values
    @(posedge clock); #1;
    t.data = pack2(155, -155); t.id = 8'd2; t.sat = '0;
    send(pack2(256, -256), 1'b1, 8'd2, t);
    t.data = pack2(0, 0); t.id = 8'd3;
    send(pack2(0, 0), 1'b0, 8'd3, t);
    t.id = 8'd4;
    send(pack2(0, 0), 1'b1, 8'd4, t);
`ifdef CORDIC_GAIN_SAT_EN
    t.data = pack2(2047, -2048); t.sat = 2'b11;
`else
    t.data = pack2(-725, 723); t.sat = 2'b00;
`endif
    t.id = 8'd5;
    send(pack2(2047, -2048), 1'b0, 8'd5, t);
    wait_drain("drain_directed");

    // Twelve back-to-back tokens: one output per clock starting at latency 3
    @(posedge clock); #1;
    pop_cyc.delete();
    acc_cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      send(pack2(i * 97 - 600, 500 - i * 83), i[0], 8'(i), mk(pack2(i * 97 - 600, 500 - i * 83), i[0], 8'(i)));
      if (i == 1) acc_cyc = cyc;
    end
    wait_drain("drain_b2b");
    check("b2b_count", pop_cyc.size(), 12);
    if (pop_cyc.size() == 12) begin
      check("b2b_first_lat", pop_cyc[0] - acc_cyc, 2);
      check("b2b_span", pop_cyc[11] - pop_cyc[0], 11);
    end

    // Stall: out_ready low under continuous input
    @(posedge clock); #1;
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 9; i++) begin
      sid = 20 + nacc;
      in_valid = 1'b1;
      in_data  = pack2(sid * 53 - 700, 900 - sid * 41);
      in_mode  = sid[0];
      in_id    = 8'(sid);
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(mk(in_data, in_mode, in_id));
        nacc++;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("stall_accepts", nacc, 3);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    // Full pipeline with output draining: new tokens enter as old ones leave
    for (int i = 0; i < 4; i++) begin
      sid = 23 + i;
      send(pack2(sid * 53 - 700, 900 - sid * 41), sid[0], 8'(sid),
           mk(pack2(sid * 53 - 700, 900 - sid * 41), sid[0], 8'(sid)));
    end
    wait_drain("drain_stall");
    repeat (3) @(negedge clock);
    check("bubble_out_valid", out_valid, 1'b0);

    // Random data and modes with random backpressure, including ID wrap
    @(posedge clock); #1;
    rnd_done = 1'b0;
    fork
      begin
        logic [DW-1:0] d;
        logic          m;
        for (int i = 0; i < 24; i++) begin
          d = DW'($urandom);
          m = 1'($urandom_range(0, 1));
          send(d, m, 8'(244 + i), mk(d, m, 8'(244 + i)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("drain_rand");

    // Reset with two tokens in flight
    @(posedge clock); #1;
    out_ready = 1'b0;
    send(pack2(100, 200), 1'b0, 8'd50, mk(pack2(100, 200), 1'b0, 8'd50));
    send(pack2(300, 400), 1'b1, 8'd51, mk(pack2(300, 400), 1'b1, 8'd51));
    @(posedge clock); #1;
    check("pre_rst_out_valid", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_id", out_id, '0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("post_rst_quiet", out_valid, 1'b0);
    end
    @(posedge clock); #1;
    send(pack2(-1000, 1000), 1'b0, 8'd60, mk(pack2(-1000, 1000), 1'b0, 8'd60));
    @(negedge clock); check("post_rst_lat1", out_valid, 1'b0);
    @(negedge clock); check("post_rst_lat2", out_valid, 1'b0);
    @(negedge clock); check("post_rst_lat3", out_valid, 1'b1);
    wait_drain("drain_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
